audio_mixer: RTL
================

# audio_mixer

Parametrised, time-multiplexed audio mixer that sums N unsigned sample channels with per-channel gain and mute, and produces one saturated unsigned sample per sample strobe. It sits between the machine core's sound sources (beeper, tape-in/tape-out monitor, future sound cards) and the shared sigma-delta DAC / I2S / SPDIF outputs in the MiST top level. It replaces the fixed single-adder mix with a per-channel, gain-controlled, clip-detecting path.

## Interface
Parameters:
- CHANNELS, 4, number of input channels (≥2).
- IN_W, 14, width of each unsigned input sample.
- OUT_W, 15, width of the unsigned output sample.
- GAIN_W, 4, width of each unsigned gain field; unity gain = 2^(GAIN_W-1).

Ports:
- clk_sys  in  1  system clock; one clock domain; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ce_sample  in  1  sample strobe; starts one mix when the block is idle.
- ch_in  in  CHANNELS*IN_W  packed unsigned samples; channel k at [k*IN_W +: IN_W].
- ch_gain  in  CHANNELS*GAIN_W  packed gains; channel k at [k*GAIN_W +: GAIN_W].
- ch_mute  in  CHANNELS  bit k=1 forces channel k's contribution to 0.
- mix_out  out  OUT_W  registered mixed sample; holds between updates.
- mix_valid  out  1  one-cycle pulse when mix_out updates.
- clip  out  1  one-cycle pulse, coincident with mix_valid, when the result saturated.
- busy  out  1  high while a mix is in progress.
- overrun  out  1  one-cycle pulse when ce_sample arrives while busy.

## Operation
- States: IDLE, ACC, DONE.
- IDLE: on ce_sample=1, snapshot ch_in, ch_gain and ch_mute into internal registers, clear accumulator and channel index, go to ACC. busy=1 from the next cycle.
- ACC: one channel per cycle, index 0..CHANNELS-1: acc += mute ? 0 : in_k * gain_k. After index CHANNELS-1, go to DONE.
- Accumulator width: IN_W + GAIN_W + clog2(CHANNELS); it never wraps.
- DONE: scaled = acc >> (GAIN_W-1), truncating toward zero. If scaled > 2^OUT_W-1, mix_out = all ones and clip=1; otherwise mix_out = scaled[OUT_W-1:0]. Pulse mix_valid and return to IDLE.
- Inputs may change freely after the snapshot. The result depends only on values present in the ce_sample cycle.
- ce_sample in ACC or DONE: ignored and overrun pulses in that cycle. The in-flight mix is unaffected.
- ce_sample is not queued. The next accepted strobe is the first one seen in IDLE.

## Timing
- Reset values: mix_out=0, mix_valid=0, clip=0, busy=0, overrun=0, state=IDLE, accumulator=0.
- ce_sample sampled high in cycle T (IDLE). Accumulation runs in cycles T+1..T+CHANNELS. mix_out, mix_valid and clip are registered and visible in cycle T+CHANNELS+1.
- busy is high in cycles T+1..T+CHANNELS+1 and low again in T+CHANNELS+2.
- Minimum strobe spacing: CHANNELS+2 cycles. A strobe exactly CHANNELS+2 cycles after the previous accepted one is accepted.
- Reset asserted mid-mix aborts it: all outputs go to reset values immediately and no mix_valid is produced for the aborted mix.
- The multiplier is combinational inside ACC (IN_W x GAIN_W); no extra pipeline stage.

## Test plan
Defaults: CHANNELS=4, IN_W=14, OUT_W=15, GAIN_W=4.
- Reset: assert reset mid-simulation, asynchronously to clk_sys -> mix_out=0, mix_valid=0, clip=0, busy=0, overrun=0 with no clock edge needed.
- Single channel: ch0=0x2000 gain 8, ch1..3 muted, strobe at T -> mix_out=0x2000 and mix_valid=1 at T+5; clip=0.
- Sum and saturation:
  - ch0, ch1 = 0x3FFF gain 8, others muted -> mix_out=0x7FFE, clip=0.
  - All four channels 0x3FFF gain 8 -> mix_out=0x7FFF, clip=1 coincident with mix_valid.
- Gain scaling: ch0=0x1000 with gain 4 -> 0x0800; gain 15 -> 0x1E00; gain 0 -> 0x0000.
- Snapshot and overrun:
  - Change ch_in to 0x3FFF at T+1 after strobing with ch0=0x0100 -> result 0x0100.
  - Strobe again at T+3 -> overrun=1 at T+3, exactly one mix_valid.
  - Strobe at T+6 -> accepted.
- Reset mid-mix: strobe at T, assert reset at T+2 -> no mix_valid; the next strobe after release produces a correct result.

Source files
------------

// File: rtl/audio_mixer.sv
// Purpose : time-multiplexed N-channel audio mixer with per-channel gain/mute and output saturation.
// Latency : ce_sample accepted in cycle T -> mix_out/mix_valid/clip visible in cycle T+CHANNELS+1.
// Backpr. : no queueing; ce_sample while busy is dropped and flagged by a same-cycle overrun pulse.
//
// Ports:
//   clk_sys    system clock, rising edge
//   reset      asynchronous active-high reset
//   ce_sample  sample strobe, starts a mix when idle
//   ch_in      packed unsigned samples, channel k at [k*IN_W +: IN_W]
//   ch_gain    packed unsigned gains, channel k at [k*GAIN_W +: GAIN_W], unity = 2^(GAIN_W-1)
//   ch_mute    bit k forces channel k's contribution to zero
//   mix_out    registered mixed sample, holds between updates
//   mix_valid  one-cycle pulse when mix_out updates
//   clip       one-cycle pulse with mix_valid when the result saturated
//   busy       high while a mix is in progress
//   overrun    one-cycle pulse when ce_sample arrives while busy
module audio_mixer #(
    parameter int CHANNELS = 4,
    parameter int IN_W     = 14,
    parameter int OUT_W    = 15,
    parameter int GAIN_W   = 4
) (
    input  logic                       clk_sys,
    input  logic                       reset,
    input  logic                       ce_sample,
    input  logic [CHANNELS*IN_W-1:0]   ch_in,
    input  logic [CHANNELS*GAIN_W-1:0] ch_gain,
    input  logic [CHANNELS-1:0]        ch_mute,
    output logic [OUT_W-1:0]           mix_out,
    output logic                       mix_valid,
    output logic                       clip,
    output logic                       busy,
    output logic                       overrun
);

    localparam int IDX_W  = $clog2(CHANNELS);
    localparam int PROD_W = IN_W + GAIN_W;
    // Wide enough for CHANNELS full-scale products, so the accumulator never wraps.
    localparam int ACC_W  = IN_W + GAIN_W + $clog2(CHANNELS);
    localparam int EXT_W  = ACC_W + OUT_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);
    // Saturation threshold, zero-extended so the compare works for any OUT_W/ACC_W relation.
    localparam logic [EXT_W-1:0] OUT_MAX  = {{ACC_W{1'b0}}, {OUT_W{1'b1}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CHANNELS*IN_W-1:0]   in_q;
    logic [CHANNELS*GAIN_W-1:0] gain_q;
    logic [CHANNELS-1:0]        mute_q;
    logic [ACC_W-1:0]           acc;
    logic [IDX_W-1:0]           idx;

    logic              start;
    logic              fin;
    logic [IN_W-1:0]   in_sel;
    logic [GAIN_W-1:0] gain_sel;
    logic [PROD_W-1:0] prod;
    logic [ACC_W-1:0]  acc_sum;
    logic [ACC_W-1:0]  scaled;
    logic [EXT_W-1:0]  scaled_ext;
    logic              sat;

    // Datapath: the current channel's product is folded into the running sum; on the
    // last channel the same combinational sum feeds the scaler so the result is
    // registered without an extra cycle.
    always_comb begin
        in_sel     = in_q[int'(idx)*IN_W +: IN_W];
        gain_sel   = gain_q[int'(idx)*GAIN_W +: GAIN_W];
        prod       = mute_q[idx] ? '0 : PROD_W'(in_sel) * PROD_W'(gain_sel);
        acc_sum    = acc + ACC_W'(prod);
        scaled     = acc_sum >> (GAIN_W - 1);
        scaled_ext = {{OUT_W{1'b0}}, scaled};
        sat        = (scaled_ext > OUT_MAX);
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        fin       = 1'b0;
        case (state)
            IDLE: begin
                if (ce_sample) begin
                    start     = 1'b1;
                    state_nxt = ACC;
                end
            end
            ACC: begin
                if (idx == LAST_IDX) begin
                    fin       = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy    = (state != IDLE);
    assign overrun = ce_sample && (state != IDLE);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            in_q      <= '0;
            gain_q    <= '0;
            mute_q    <= '0;
            acc       <= '0;
            idx       <= '0;
            mix_out   <= '0;
            mix_valid <= 1'b0;
            clip      <= 1'b0;
        end else begin
            state     <= state_nxt;
            mix_valid <= fin;
            clip      <= fin && sat;
            if (start) begin
                in_q   <= ch_in;
                gain_q <= ch_gain;
                mute_q <= ch_mute;
                acc    <= '0;
                idx    <= '0;
            end else if (state == ACC) begin
                acc <= acc_sum;
                idx <= idx + IDX_W'(1);
            end
            if (fin) begin
                mix_out <= sat ? {OUT_W{1'b1}} : scaled_ext[OUT_W-1:0];
            end
        end
    end

endmodule
